// File: rtl/regfile_list_sequencer.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list in ascending order,
// moving words between the register file and data memory, with optional base writeback.
module regfile_list_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        up,
  input  logic        pre,
  input  logic        wb_en,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_addr,
  input  logic [15:0] reg_list,
  output logic [3:0]  rf_ra,
  input  logic [31:0] rf_rd,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        pc_we,
  output logic [31:0] pc_wd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CALC, XFER, WB, DONE} state_t;

  state_t      state;
  logic        is_load_q;
  logic        up_q;
  logic        pre_q;
  logic        wb_en_q;
  logic [3:0]  base_reg_q;
  logic [31:0] base_q;
  logic [15:0] list_q;
  logic [15:0] remaining;
  logic [31:0] final_q;

  logic [4:0]  count;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] final_value;
  logic [15:0] remaining_next;
  logic [3:0]  first_reg;
  logic [3:0]  next_reg;
  logic        wb_suppress;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  // Scanning from the top leaves the lowest set index as the final assignment.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count          = popcount16(list_q);
    span           = {25'd0, count, 2'b00};
    start_addr     = base_q;
    unique case ({up_q, pre_q})
      2'b10: start_addr = base_q;
      2'b11: start_addr = base_q + 32'd4;
      2'b00: start_addr = base_q - span + 32'd4;
      2'b01: start_addr = base_q - span;
    endcase
    final_value    = up_q ? (base_q + span) : (base_q - span);
    remaining_next = remaining & ~(16'd1 << rf_ra);
    first_reg      = lowest_set(list_q);
    next_reg       = lowest_set(remaining_next);
    wb_suppress    = (base_reg_q == 4'd15) || (is_load_q && list_q[base_reg_q]);
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign mem_req = (state == XFER);
  assign mem_we  = mem_req && !is_load_q;
  assign mem_wd  = mem_we ? rf_rd : 32'd0;

  // Register-port writes are registered, so each one lands the cycle after the state
  // that decides it: the final load write falls in WB, the base writeback in DONE.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      is_load_q  <= 1'b0;
      up_q       <= 1'b0;
      pre_q      <= 1'b0;
      wb_en_q    <= 1'b0;
      base_reg_q <= '0;
      base_q     <= '0;
      list_q     <= '0;
      remaining  <= '0;
      final_q    <= '0;
      rf_ra      <= '0;
      mem_addr   <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
      pc_we      <= 1'b0;
      pc_wd      <= '0;
    end else begin
      rf_we <= 1'b0;
      pc_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            is_load_q  <= is_load;
            up_q       <= up;
            pre_q      <= pre;
            wb_en_q    <= wb_en;
            base_reg_q <= base_reg;
            base_q     <= base_addr;
            list_q     <= reg_list;
            state      <= CALC;
          end
        end
        CALC: begin
          final_q <= final_value;
          if (count == 5'd0) begin
            state <= DONE;
          end else begin
            remaining <= list_q;
            rf_ra     <= first_reg;
            mem_addr  <= {start_addr[31:2], 2'b00};
            state     <= XFER;
          end
        end
        XFER: begin
          if (mem_ack) begin
            if (is_load_q) begin
              if (rf_ra == 4'd15) begin
                pc_we <= 1'b1;
                pc_wd <= mem_rd;
              end else begin
                rf_we <= 1'b1;
                rf_wa <= rf_ra;
                rf_wd <= mem_rd;
              end
            end
            remaining <= remaining_next;
            mem_addr  <= mem_addr + 32'd4;
            if (remaining_next == 16'd0) state <= wb_en_q ? WB : DONE;
            else                         rf_ra <= next_reg;
          end
        end
        WB: begin
          if (!wb_suppress) begin
            rf_we <= 1'b1;
            rf_wa <= base_reg_q;
            rf_wd <= final_q;
          end
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
